psg_wave_gen: RTL
=================

PSG_WAVE_GEN -- requirements
Module: psg_wave_gen

Interface
REQ-001 SHALL have parameter WID, default 12, meaning output waveform width; legal values are 8 to 16.
REQ-002 SHALL have parameter SEED, default 23'h7FFFF8, meaning the noise LFSR value after reset or test.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ce, input, 1 bit: sample-rate enable; state advances only on cycles where ce=1.
REQ-006 SHALL have port freq, input, 16 bits: phase increment added per ce.
REQ-007 SHALL have port pw, input, 12 bits: pulse-width threshold.
REQ-008 SHALL have port test, input, 1 bit: holds the accumulator and LFSR in their cleared/seed state.
REQ-009 SHALL have ports sync_en and ring_en, inputs, 1 bit each: hard-sync and ring-modulation enables.
REQ-010 SHALL have ports sync_in and ring_in, inputs, 1 bit each: the acc_msb of the modulating voice.
REQ-011 SHALL have port acc_msb, output, 1 bit: accumulator bit 23, for chaining into other voices.
REQ-012 SHALL have ports wav_tri, wav_saw, wav_pul, wav_noi and wav_sub, outputs, WID bits each: the five waveforms, registered, feeding mux inputs a..e in that order.

Function
REQ-013 SHALL keep a 24-bit phase accumulator acc; on ce, acc <= acc + zero-extended freq, modulo 2^24 (wrap, no saturation).
REQ-014 SHALL register sync_in on each ce as sync_d; a sync event occurs when ce=1, sync_en=1, sync_in=1 and sync_d=0.
REQ-015 SHALL apply this priority on a ce cycle: test first (acc<=0, LFSR<=SEED, sub<=0), then sync event (acc<=0), then normal add.
REQ-016 SHALL hold every state element when ce=0, regardless of test, sync or freq changes.
REQ-017 SHALL keep a 23-bit LFSR; it shifts left when a ce cycle changes acc[19] from 0 to 1, with new bit0 = bit22 XOR bit17.
REQ-018 SHALL keep a sub-octave flop sub that toggles when a ce cycle changes acc[23] from 1 to 0.
REQ-019 SHALL form WID-bit waveforms from the 12-bit forms below: truncate LSBs if WID<12, zero-pad LSBs if WID>12.
REQ-020 SHALL compute triangle as: t = acc[23] XOR (ring_en AND ring_in); tri = t ? ~acc[22:11] : acc[22:11].
REQ-021 SHALL compute sawtooth as saw = acc[23:12].
REQ-022 SHALL compute pulse as 12'hFFF when acc[23:12] >= pw or test=1, else 12'h000; pw=0 therefore always gives FFF.
REQ-023 SHALL compute noise as {L22,L20,L16,L13,L11,L7,L4,L2, 4'b0000}, where Ln is LFSR bit n.
REQ-024 SHALL compute the sub-octave square as {12{sub}}.
REQ-025 SHALL register all outputs, including acc_msb, from post-update state, with 1-cycle latency after the ce cycle that updates state.
REQ-026 SHALL change outputs only on the cycle after a ce cycle.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, regardless of ce, set acc=0, LFSR=SEED, sub=0 and sync_d=0.
REQ-028 SHALL, on that same reset edge, set all wav_* outputs to 0 and acc_msb=0.
REQ-029 SHALL make reset dominate test, sync and ce, including reset asserted mid-cycle of a sync or LFSR step.

Structure
REQ-030 SHALL place the PSG constants in the shared psg_pkg package: ACC_W=24, NOISE_W=23, SEED default, and LFSR tap indices.
REQ-031 SHALL implement the LFSR as sub-module psg_lfsr, with ports clk, rst, ld (seed), step and q[22:0].

Verification
REQ-032 SHALL verify ramp: freq=16'h1000 with ce every cycle gives wav_saw stepping 0,1,2,... (12-bit) and acc_msb rising after 2048 ce cycles.
REQ-033 SHALL verify pulse: pw=12'h800 with freq=16'h1000 gives wav_pul=000 for 2048 ce cycles then FFF for 2048; pw=0 gives constant FFF.
REQ-034 SHALL verify triangle/ring: with ring_en=1 and ring_in=1, wav_tri equals the complement of the ring_en=0 output at identical acc.
REQ-035 SHALL verify sync: sync_en=1 with a sync_in 0->1 on a ce cycle gives wav_saw=0 on the next output; with sync_en=0 there is no effect.
REQ-036 SHALL verify noise: after rst, the first wav_noi after acc[19] first rises matches a model LFSR step from 7FFFF8; test=1 restores the seed.
REQ-037 SHALL verify ce gating and reset: ce=0 for 100 cycles leaves all outputs frozen; rst asserted mid-run zeroes all outputs on the next edge.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared constants and helpers for the PSG voice blocks.
// Holds the accumulator/LFSR widths, the default noise seed, the
// LFSR feedback tap indices and two small helpers shared between the
// LFSR sub-module and the waveform generator.
package psg_pkg;

  localparam int ACC_W    = 24;
  localparam int NOISE_W  = 23;
  localparam int WAVE_W   = 12;

  localparam logic [NOISE_W-1:0] SEED_DEFAULT = 23'h7FFFF8;

  // Feedback taps: new bit0 = q[TAP_HI] ^ q[TAP_LO]
  localparam int TAP_HI = 22;
  localparam int TAP_LO = 17;

  // Accumulator bit whose rising edge clocks the noise LFSR
  localparam int NOISE_CLK_BIT = 19;

  // One shift of the noise register
  function automatic logic [NOISE_W-1:0] lfsr_advance(input logic [NOISE_W-1:0] q);
    return {q[NOISE_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
  endfunction

  // Noise waveform: eight scattered LFSR bits on top, four zero LSBs
  function automatic logic [WAVE_W-1:0] noise_pick(input logic [NOISE_W-1:0] q);
    return {q[22], q[20], q[16], q[13], q[11], q[7], q[4], q[2], 4'b0000};
  endfunction

endpackage

// File: rtl/psg_lfsr.sv
// 23-bit noise LFSR.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, loads SEED
//   ld   - load SEED (used while the voice is held in test)
//   step - shift left once, feeding back bit22 ^ bit17
//   q    - current register value
module psg_lfsr
  import psg_pkg::*;
#(
  parameter logic [NOISE_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic               step,
  output logic [NOISE_W-1:0] q
);

  // Reset and load both return the register to the seed; load wins over step
  // so a voice held in test never drifts away from the seed.
  always_ff @(posedge clk) begin
    if (rst || ld) begin
      q <= SEED;
    end else if (step) begin
      q <= lfsr_advance(q);
    end
  end

endmodule

// File: rtl/psg_wave_gen.sv
// PSG voice waveform generator.
// A 24-bit phase accumulator advanced on each sample enable produces
// triangle, sawtooth, pulse, noise and sub-octave square waveforms,
// all registered and scaled to WID bits.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   ce                - sample-rate enable; state moves only when high
//   freq[15:0]        - phase increment per sample
//   pw[11:0]          - pulse-width threshold
//   test              - holds accumulator, LFSR and sub-octave cleared
//   sync_en, sync_in  - hard sync enable and modulating voice acc_msb
//   ring_en, ring_in  - ring modulation enable and modulating acc_msb
//   acc_msb           - registered accumulator bit 23 for chaining
//   wav_tri/saw/pul/noi/sub - registered waveforms (mux inputs a..e)
module psg_wave_gen
  import psg_pkg::*;
#(
  parameter int                 WID  = 12,
  parameter logic [NOISE_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic [15:0]    freq,
  input  logic [11:0]    pw,
  input  logic           test,
  input  logic           sync_en,
  input  logic           ring_en,
  input  logic           sync_in,
  input  logic           ring_in,
  output logic           acc_msb,
  output logic [WID-1:0] wav_tri,
  output logic [WID-1:0] wav_saw,
  output logic [WID-1:0] wav_pul,
  output logic [WID-1:0] wav_noi,
  output logic [WID-1:0] wav_sub
);

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic               sync_d;
  logic               sync_event;
  logic               sub;
  logic               sub_next;
  logic               lfsr_ld;
  logic               lfsr_step;
  logic [NOISE_W-1:0] lfsr_q;
  logic [NOISE_W-1:0] lfsr_post;
  logic               tri_flip;
  logic [WAVE_W-1:0]  tri12;
  logic [WAVE_W-1:0]  saw12;
  logic [WAVE_W-1:0]  pul12;
  logic [WAVE_W-1:0]  noi12;
  logic [WAVE_W-1:0]  sub12;

  // Narrow by dropping LSBs or widen by padding zero LSBs: place the
  // 12-bit form at the top of a wide word and take the top WID bits.
  function automatic logic [WID-1:0] scale(input logic [WAVE_W-1:0] v);
    logic [27:0] t;
    t = {v, 16'h0000};
    return t[27 -: WID];
  endfunction

  psg_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .ld   (lfsr_ld),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  // Next-state computation. Test overrides sync, sync overrides the add.
  // lfsr_post mirrors what the LFSR will hold after this sample so the
  // noise output register can load the post-update value in the same edge.
  always_comb begin
    sync_event = sync_en & sync_in & ~sync_d;
    acc_next   = acc;
    sub_next   = sub;
    lfsr_ld    = 1'b0;
    lfsr_step  = 1'b0;
    lfsr_post  = lfsr_q;
    if (test) begin
      acc_next  = '0;
      sub_next  = 1'b0;
      lfsr_ld   = ce;
      lfsr_post = SEED;
    end else begin
      if (sync_event) begin
        acc_next = '0;
      end else begin
        acc_next = acc + {8'h00, freq};
      end
      if (!acc[NOISE_CLK_BIT] && acc_next[NOISE_CLK_BIT]) begin
        lfsr_step = ce;
        lfsr_post = lfsr_advance(lfsr_q);
      end
      if (acc[ACC_W-1] && !acc_next[ACC_W-1]) begin
        sub_next = ~sub;
      end
    end
  end

  // Waveform shaping from the post-update state.
  always_comb begin
    tri_flip = acc_next[23] ^ (ring_en & ring_in);
    tri12    = tri_flip ? ~acc_next[22:11] : acc_next[22:11];
    saw12    = acc_next[23:12];
    pul12    = ((saw12 >= pw) || test) ? 12'hFFF : 12'h000;
    noi12    = noise_pick(lfsr_post);
    sub12    = {WAVE_W{sub_next}};
  end

  // Voice state only moves on sample enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      sub    <= 1'b0;
      sync_d <= 1'b0;
    end else if (ce) begin
      acc    <= acc_next;
      sub    <= sub_next;
      sync_d <= sync_in;
    end
  end

  // Output registers load alongside the state, so they show the new
  // sample in the cycle after the enable and are frozen otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_msb <= 1'b0;
      wav_tri <= '0;
      wav_saw <= '0;
      wav_pul <= '0;
      wav_noi <= '0;
      wav_sub <= '0;
    end else if (ce) begin
      acc_msb <= acc_next[ACC_W-1];
      wav_tri <= scale(tri12);
      wav_saw <= scale(saw12);
      wav_pul <= scale(pul12);
      wav_noi <= scale(noi12);
      wav_sub <= scale(sub12);
    end
  end

endmodule
